complex_mac_stream: RTL
=======================

# complex_mac_stream

Parametrised streaming complex multiply-accumulate. It computes res = Σ_{k=0..N-1} X_k·Y_k over N operand pairs fed one pair per cycle through a valid/ready port. The element format is generic, signed W-bit components. An optional conjugate mode computes Σ X_k·conj(Y_k). It supersedes the fixed 4-term, 4-bit parallel-input MAC in the complex-arithmetic datapath, using the same start/ready command handshake and the same {real, imag} packing.

## Interface
- W, 4: component width; real and imaginary parts are signed two's complement, W ≥ 2.
- N, 4: terms per dot product, N ≥ 1.
- RW, 2*W+1+$clog2(N): result component width (localparam, derived). It is wide enough that no overflow is possible.
- clk  in  1  single clock; all logic is clocked on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  command strobe; sampled in IDLE and DONE only.
- conj  in  1  mode, sampled together with an accepted start. 0 gives X·Y; 1 gives X·conj(Y).
- in_valid  in  1  an operand pair is present on x/y.
- in_ready  out  1  block accepts a pair this cycle.
- x  in  2*W  operand {real, imag}.
- y  in  2*W  operand {real, imag}.
- busy  out  1  high in LOAD and DRAIN.
- ready  out  1  result valid; a level signal held through DONE.
- res  out  2*RW  result {real, imag}, each part signed.

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - start=1 latches conj, clears the accumulator and term counter, and moves to LOAD.
- LOAD:
  - in_ready=1. A pair is accepted when in_valid=1.
  - Each accepted pair increments the term counter.
  - The Nth accept moves to DRAIN.
- DRAIN:
  - in_ready=0. Waits for the last product to reach the accumulator, then moves to DONE.
- DONE:
  - ready=1 and res is held stable.
  - start=1 behaves as in IDLE: it clears res to 0, deasserts ready and moves to LOAD.
- Datapath stage 1 registers four signed 2W-bit partial products: ar·br, ai·bi, ar·bi, ai·br.
- Datapath stage 2 forms the term and adds it into the RW-bit accumulator with sign extension:
  - conj=0: re = ar·br − ai·bi; im = ar·bi + ai·br.
  - conj=1: re = ar·br + ai·bi; im = ai·br − ar·bi.
- start is ignored in LOAD and DRAIN; conj changes there have no effect.
- in_valid is ignored whenever in_ready=0.
- No saturation or wrap is needed, because RW bounds the worst case N·2^(2W−1).
- Reset values: state IDLE; in_ready, busy and ready are 0; res, accumulator, counter and pipeline valid bits are 0.

## Timing
- An accept on edge t is registered in stage 1 at edge t+1 and accumulated at edge t+2.
- The last (Nth) accept on edge t gives ready=1 and a valid res after edge t+2.
- Minimum latency: start sampled at edge 0, accepts at edges 1..N, ready after edge N+2.
- in_valid gaps stall only the input; the pipeline keeps draining. There is no bubble penalty beyond the gap itself.
- in_ready is combinational from state only; it never depends on in_valid.
- start together with in_valid in IDLE: only start acts, and no pair is accepted in that cycle.
- start in DONE: ready=0 and res=0 after the same edge; the first accept can occur on the next edge.
- rst at any time, including mid-LOAD or mid-DRAIN, forces all reset values at the next edge. In-flight pipeline data is discarded, and no stale partial sum may leak into the next result.

## Structure
- Shared package complex_mac_pkg holds:
  - the state enum: IDLE, LOAD, DRAIN, DONE;
  - a helper that derives RW from W and N;
  - the {real, imag} packing/unpacking functions used across the complex datapath.
- One sub-module, complex_mult_pipe. It takes x, y, conj and a valid flag, and outputs a registered product pair of width 2W+1 with its valid flag. The FSM, counter and accumulator live in the top module.

## Test plan
All scenarios use W=4, N=4, RW=11.
- Back-to-back operation: reset, start with conj=0, four pairs x=(1+2i), y=(3+4i) with in_valid held high. Required: res=(−20+40i), and ready rises exactly after edge 6 counted from the start edge.
- Conjugate mode: same data with conj=1. Required: res=(44+8i).
- Extreme values: all components −8, i.e. x=y=(−8−8i). conj=0 gives res=(0+512i); conj=1 gives res=(512+0i). No overflow in either case.
- Stalled input: in_valid high only on alternate cycles, with the data from the back-to-back case. Required: res=(−20+40i); ready two edges after the 4th accept; in_ready high throughout LOAD; start pulses in LOAD are ignored.
- Reset mid-operation: assert rst after 2 accepts. Required: all outputs 0 on the next edge. A subsequent run with x=(1+0i), y=(2+0i) ×4 must give res=(8+0i).
- Restart from DONE: with ready=1, pulse start. Required: ready=0 and res=0 on the next edge, followed by a correct new result with no remnant of the previous sum.

Source files
------------

// File: rtl/complex_mac_pkg.sv
// Shared types and helpers for the complex-arithmetic datapath: FSM states, result-width
// derivation and the {real, imag} packing used on every complex bus.
package complex_mac_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StDone
  } state_e;

  // Widest component the pack/unpack helpers carry; callers zero-extend into it.
  localparam int unsigned MaxW = 64;

  function automatic int unsigned calc_rw(input int unsigned w, input int unsigned n);
    return 2 * w + 1 + $clog2(n);
  endfunction

  // Real part of a {real, imag} bus with w-bit components (caller truncates to w).
  function automatic logic [MaxW-1:0] cplx_re(input logic [2*MaxW-1:0] v, input int unsigned w);
    return MaxW'(v >> w);
  endfunction

  // Imaginary part sits in the low bits; caller truncates to its component width.
  function automatic logic [MaxW-1:0] cplx_im(input logic [2*MaxW-1:0] v);
    return MaxW'(v);
  endfunction

  // Operands must arrive zero-extended above bit w-1.
  function automatic logic [2*MaxW-1:0] cplx_pack(input logic [MaxW-1:0] re,
                                                  input logic [MaxW-1:0] im,
                                                  input int unsigned w);
    return ((2 * MaxW)'(re) << w) | (2 * MaxW)'(im);
  endfunction

endpackage

// File: rtl/complex_mult_pipe.sv
// Two-stage complex multiplier: an operand capture stage, then four registered partial
// products combined into a (2W+1)-bit product pair, optionally against conj(y).
module complex_mult_pipe
  import complex_mac_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*W-1:0]      x_i,
  input  logic [2*W-1:0]      y_i,
  input  logic                conj_i,
  input  logic                valid_i,
  output logic signed [2*W:0] re_o,
  output logic signed [2*W:0] im_o,
  output logic                valid_o
);

  logic [2*W-1:0] x_q, y_q;
  logic           in_vld_q;
  logic           conj_q;
  logic           pp_vld_q;

  logic signed [W-1:0]   ar, ai, br, bi;
  logic signed [2*W-1:0] pp_rr_q, pp_ii_q, pp_ri_q, pp_ir_q;

  assign ar = W'(cplx_re((2 * MaxW)'(x_q), W));
  assign ai = W'(cplx_im((2 * MaxW)'(x_q)));
  assign br = W'(cplx_re((2 * MaxW)'(y_q), W));
  assign bi = W'(cplx_im((2 * MaxW)'(y_q)));

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      in_vld_q <= 1'b0;
      conj_q   <= 1'b0;
      pp_vld_q <= 1'b0;
      pp_rr_q  <= '0;
      pp_ii_q  <= '0;
      pp_ri_q  <= '0;
      pp_ir_q  <= '0;
    end else begin
      in_vld_q <= valid_i;
      pp_vld_q <= in_vld_q;
      conj_q   <= conj_i;
      if (valid_i) begin
        x_q <= x_i;
        y_q <= y_i;
      end
      if (in_vld_q) begin
        pp_rr_q <= (2 * W)'(ar) * (2 * W)'(br);
        pp_ii_q <= (2 * W)'(ai) * (2 * W)'(bi);
        pp_ri_q <= (2 * W)'(ar) * (2 * W)'(bi);
        pp_ir_q <= (2 * W)'(ai) * (2 * W)'(br);
      end
    end
  end

  always_comb begin
    re_o = '0;
    im_o = '0;
    if (conj_q) begin
      re_o = (2 * W + 1)'(pp_rr_q) + (2 * W + 1)'(pp_ii_q);
      im_o = (2 * W + 1)'(pp_ir_q) - (2 * W + 1)'(pp_ri_q);
    end else begin
      re_o = (2 * W + 1)'(pp_rr_q) - (2 * W + 1)'(pp_ii_q);
      im_o = (2 * W + 1)'(pp_ri_q) + (2 * W + 1)'(pp_ir_q);
    end
  end

  assign valid_o = pp_vld_q;

endmodule

// File: rtl/complex_mac_stream.sv
// Streaming complex dot product: accepts N operand pairs over valid/ready after a start
// command and presents the accumulated {real, imag} sum with a level ready flag.
module complex_mac_stream
  import complex_mac_pkg::*;
#(
  parameter  int unsigned W  = 4,
  parameter  int unsigned N  = 4,
  localparam int unsigned RW = calc_rw(W, N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            conj,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*W-1:0]  x,
  input  logic [2*W-1:0]  y,
  output logic            busy,
  output logic            ready,
  output logic [2*RW-1:0] res
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  state_e                state_q;
  logic                  busy_q, ready_q, conj_q;
  logic [CntW-1:0]       in_cnt_q, acc_cnt_q;
  logic signed [RW-1:0]  acc_re_q, acc_im_q;
  logic                  fire;
  logic signed [2*W:0]   term_re, term_im;
  logic                  term_vld;

  assign in_ready = (state_q == StLoad);
  assign fire     = in_ready & in_valid;

  complex_mult_pipe #(
    .W(W)
  ) u_mult (
    .clk    (clk),
    .rst    (rst),
    .x_i    (x),
    .y_i    (y),
    .conj_i (conj_q),
    .valid_i(fire),
    .re_o   (term_re),
    .im_o   (term_im),
    .valid_o(term_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      conj_q    <= 1'b0;
      in_cnt_q  <= '0;
      acc_cnt_q <= '0;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q   <= StLoad;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            conj_q    <= conj;
            in_cnt_q  <= '0;
            acc_cnt_q <= '0;
            acc_re_q  <= '0;
            acc_im_q  <= '0;
          end
        end
        StLoad, StDrain: begin
          if (term_vld) begin
            acc_re_q  <= acc_re_q + RW'(term_re);
            acc_im_q  <= acc_im_q + RW'(term_im);
            acc_cnt_q <= acc_cnt_q + 1'b1;
          end
          if (state_q == StLoad && fire) begin
            in_cnt_q <= in_cnt_q + 1'b1;
            if (in_cnt_q == LastCnt) state_q <= StDrain;
          end
          // The Nth product landing in the accumulator completes the sum.
          if (state_q == StDrain && term_vld && acc_cnt_q == LastCnt) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy  = busy_q;
  assign ready = ready_q;
  assign res   = (2 * RW)'(cplx_pack(MaxW'($unsigned(acc_re_q)), MaxW'($unsigned(acc_im_q)), RW));

endmodule
